mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: the CPU instruction-fetch port (I, read-only) and the CPU data port (D, read/write).
- Sits between the multicycle core and the unified memory model.
- Runs a request/ready handshake per port and a single-transaction FSM with a configurable fixed memory latency.
- Uses round-robin arbitration when both ports request in the same cycle.

Parameters:
ADDR_W  32  address width, all ports
DATA_W  32  data width, all ports
MEM_LATENCY  2  cycles from the m_en cycle until m_rdata is valid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
i_req  input  1  instruction-fetch read request, level, held until i_ready
i_addr  input  ADDR_W  fetch address
i_rdata  output  DATA_W  fetched word, registered
i_ready  output  1  one-cycle completion pulse for I
d_req  input  1  data request, level, held until d_ready
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_rdata  output  DATA_W  read data, registered
d_ready  output  1  one-cycle completion pulse for D
m_en  output  1  memory access strobe, one cycle per transaction
m_we  output  1  memory write enable, never high unless m_en is high
m_addr  output  ADDR_W  memory address, registered
m_wdata  output  DATA_W  memory write data, registered
m_rdata  input  DATA_W  memory read data
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high; clock clk, reset rst):
  - State goes to IDLE.
  - m_en, m_we, i_ready, d_ready and busy are 0.
  - m_addr, m_wdata, i_rdata and d_rdata are 0.
  - last_grant is set to D, so the first tie goes to I.
  - A reset asserted mid-transaction aborts it: no ready pulse is issued, and the requester must re-issue.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - At a rising edge, if exactly one req is high, that port is granted.
  - If both are high, the port not equal to last_grant is granted, and last_grant is updated to it.
  - On grant: latch addr, wdata and we (we is forced to 0 for I) into the m_* registers, load cnt = MEM_LATENCY, and go to ISSUE.
  - If neither req is high, stay in IDLE.
- ISSUE: one cycle.
  - m_en = 1; m_we = latched we.
  - Next state is WAIT.
- WAIT:
  - m_en = 0 and m_we = 0; cnt decrements each edge.
  - When cnt == 1 at an edge: if the transaction is a read, capture m_rdata into the granted port's rdata register, then go to RESP.
  - Writes wait the same number of cycles, so timing is uniform.
- RESP: one cycle.
  - The granted port's ready = 1.
  - Next state is IDLE.
- Latency: req sampled at edge T0 → ISSUE in cycle T0+1 → WAIT lasts MEM_LATENCY cycles → ready high in cycle T0+MEM_LATENCY+2.
  - With the default latency of 2, ready is high 4 cycles after the sampling edge.
- Handshake rules:
  - A requester holds req, addr, we and wdata stable until it sees ready.
  - The requester must drop or replace req at the edge that ends the ready cycle.
  - The arbiter re-samples only in IDLE, which is one cycle after RESP, so a stale req is never double-granted.
- Throughput: at most one transaction per MEM_LATENCY+3 cycles.
- A request arriving while busy waits; it is never dropped.
- rdata registers:
  - Each rdata register holds its value until that port's next read completion.
  - A D write leaves d_rdata unchanged.
- Fairness: under continuous dual requests, grants strictly alternate I, D, I, D, …
- Addresses pass through unmodified; no alignment check and no address decode.
- Inputs sampled outside IDLE are ignored. Changes to addr/wdata after the grant do not affect the in-flight transaction.

Test Plan:
1. Reset then single I read: i_req=1, i_addr=0x00400000, memory returns 0x00A00093 → m_en pulses in cycle 1 with m_we=0; i_ready high in cycle 4; i_rdata=0x00A00093; d_ready stays 0.
2. D write then read: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → m_en=m_we=1 for one cycle with m_wdata=0xDEADBEEF; d_ready high 4 cycles after sampling; d_rdata unchanged. Then a read of 0x10 → d_rdata=0xDEADBEEF.
3. Simultaneous requests right after reset: I and D both request continuously for 4 transactions → grant order I, D, I, D; exactly one ready per transaction; never two m_en pulses within 5 cycles.
4. Request while busy: d_req rises during I's WAIT → D is granted in the IDLE cycle after I's RESP; d_addr is latched at grant, not at the earlier req edge.
5. Reset mid-transaction: rst asserted during WAIT → next cycle state is IDLE with all outputs 0 and no ready pulse; I re-issues and completes normally.
6. MEM_LATENCY=1 and MEM_LATENCY=15 builds: ready arrives exactly 3 and 17 cycles after the sampling edge respectively, and captured rdata matches the memory model.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch (I) and data (D) ports onto one single-port synchronous memory.
// One transaction is in flight at a time. The memory latency is fixed. Simultaneous requests alternate round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_gnt_d;
  logic              r_last_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_any_req;
  logic              w_pick_d;
  logic              w_grant;
  logic              w_last_wait;
  logic              w_m_en;
  logic              w_m_we;
  logic              w_i_ready;
  logic              w_d_ready;

  // On a tie, the port that did not win the last tie gets the grant.
  assign w_any_req   = i_req | d_req;
  assign w_pick_d    = d_req & (~i_req | ~r_last_d);
  assign w_grant     = (r_state == ST_IDLE) && w_any_req;
  assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_m_en       = 1'b0;
    w_m_we       = 1'b0;
    w_i_ready    = 1'b0;
    w_d_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_m_en       = 1'b1;
        w_m_we       = r_we;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        w_i_ready    = ~r_gnt_d;
        w_d_ready    = r_gnt_d;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_d <= w_pick_d;
        if (i_req && d_req) r_last_d <= w_pick_d;
        r_we    <= w_pick_d & d_we;
        r_addr  <= w_pick_d ? d_addr : i_addr;
        if (w_pick_d) r_wdata <= d_wdata;
        r_cnt   <= LAT;
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt - 4'd1;
      // Writes spend the same time in WAIT but never touch the rdata registers.
      if (w_last_wait && !r_we) begin
        if (r_gnt_d) r_d_rdata <= m_rdata;
        else         r_i_rdata <= m_rdata;
      end
    end
  end

  assign m_en    = w_m_en;
  assign m_we    = w_m_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign i_ready = w_i_ready;
  assign d_ready = w_d_ready;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != ST_IDLE);

endmodule
